// File: rtl/fir_mac_if.sv
// Bus between the FIR MAC engine and its environment: sample source, coefficient memory,
// external multiplier and the downstream result consumer.
interface fir_mac_if #(
  parameter int Width = 16,
  parameter int AW    = 3
);
  logic [Width-1:0] sample_in;
  logic             sample_valid;
  logic [AW-1:0]    coef_addr;
  logic [Width-1:0] coef_data;
  logic [Width-1:0] mult_a;
  logic [Width-1:0] mult_b;
  logic [Width-1:0] mult_y;
  logic [Width-1:0] y_out;
  logic             y_valid;
  logic             busy;
  logic             sample_drop;

  modport master (
    input  sample_in, sample_valid, coef_data, mult_y,
    output coef_addr, mult_a, mult_b, y_out, y_valid, busy, sample_drop
  );

  modport slave (
    output sample_in, sample_valid, coef_data, mult_y,
    input  coef_addr, mult_a, mult_b, y_out, y_valid, busy, sample_drop
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Time-multiplexed N-tap FIR: one tap per clock through an external Q5.10 multiplier,
// saturating accumulation in fixed tap order, registered result with a one-cycle valid.
//
//   state | meaning
//   IDLE  | waiting for sample_valid; accepting edge shifts the delay line
//   MAC   | tap idx on the multiplier, product accumulated at each edge
//   DONE  | acc copied to y_out, y_valid raised on the way back to IDLE
module fir_mac_seq #(
  parameter int f     = 10,
  parameter int p     = 5,
  parameter int Width = f + p + 1,
  parameter int N     = 8,
  parameter int AW    = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  fir_mac_if.master bus
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic [Width-1:0] acc_q;
  logic [Width-1:0] acc_d;
  logic [Width-1:0] x_q [N];
  logic [Width-1:0] y_out_q;
  logic             y_valid_q;
  logic             drop_q;
  logic             in_mac;

  // Clamp on overflow of the (Width+1)-bit sum instead of wrapping.
  function automatic logic [Width-1:0] sat_add(input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
    logic [Width:0] s;
    s = {a[Width-1], a} + {b[Width-1], b};
    if (s[Width] != s[Width-1])
      return s[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    return s[Width-1:0];
  endfunction

  assign in_mac = (state_q == MAC);
  assign acc_d  = sat_add(acc_q, bus.mult_y);

  assign bus.coef_addr   = in_mac ? idx_q : '0;
  assign bus.mult_a      = in_mac ? x_q[idx_q] : '0;
  assign bus.mult_b      = in_mac ? bus.coef_data : '0;
  assign bus.y_out       = y_out_q;
  assign bus.y_valid     = y_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sample_drop = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      for (int k = 0; k < N; k++) x_q[k] <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      drop_q    <= bus.sample_valid && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            for (int k = N - 1; k > 0; k--) x_q[k] <= x_q[k-1];
            x_q[0]  <= bus.sample_in;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (idx_q == AW'(N - 1)) state_q <= DONE;
          else                     idx_q   <= idx_q + AW'(1);
        end
        DONE: begin
          y_out_q   <= acc_q;
          y_valid_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed and randomized bench for fir_mac_seq with a behavioural FIR reference model,
// a coefficient ROM and a saturating Q5.10 multiplier standing in for Mult.
module tb_fir_mac_seq;
  localparam int W  = 16;
  localparam int NT = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [W-1:0] coef [NT];
  logic [W-1:0] mx   [NT];

  fir_mac_if #(.Width(W), .AW(3)) bus ();

  fir_mac_seq #(.N(NT), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mult_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    int pr;
    pr = $signed(a) * $signed(b);
    pr = pr >>> 10;
    if (pr > 32767)  pr = 32767;
    if (pr < -32768) pr = -32768;
    return pr[W-1:0];
  endfunction

  always_comb begin
    bus.coef_data = coef[bus.coef_addr];
    bus.mult_y    = mult_fn(bus.mult_a, bus.mult_b);
  end

  function automatic logic [W-1:0] model_eval();
    int acc;
    int pr;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      pr  = $signed(mult_fn(mx[k], coef[k]));
      acc = acc + pr;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
    end
    return acc[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_y_out", bus.y_out, 0);
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.sample_drop, 0);
    chk("rst_coef_addr", bus.coef_addr, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    chk("rst_mult_b", bus.mult_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NT; k++) mx[k] = '0;
  endtask

  // One accepted sample; optional second strobe sampled at edge drop_edge (1..9) must be dropped.
  task automatic send(input logic [W-1:0] v, input int drop_edge, input logic [W-1:0] drop_v,
                      output logic [W-1:0] y);
    logic [W-1:0] exp;
    @(negedge clk);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = v;
    exp   = model_eval();
    y     = '0;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 0 || c == drop_edge) bus.sample_valid = 1'b0;
      chk("y_valid", bus.y_valid, (c == 9));
      chk("busy", bus.busy, (c <= 8));
      chk("sample_drop", bus.sample_drop, (drop_edge > 0 && c == drop_edge));
      if (c < NT) begin
        chk("coef_addr", bus.coef_addr, c);
        chk("mult_a", bus.mult_a, mx[c]);
        chk("mult_b", bus.mult_b, coef[c]);
      end else begin
        chk("coef_addr_idle", bus.coef_addr, 0);
        chk("mult_a_idle", bus.mult_a, 0);
        chk("mult_b_idle", bus.mult_b, 0);
      end
      if (c == 9) begin
        y = bus.y_out;
        chk("y_out", bus.y_out, exp);
      end
      if (c == 10) chk("y_out_hold", bus.y_out, exp);
      if (drop_edge > 0 && c == drop_edge - 1) begin
        bus.sample_in    = drop_v;
        bus.sample_valid = 1'b1;
      end
    end
  endtask

  task automatic run_impulse();
    logic [W-1:0] y;
    for (int k = 0; k < NT; k++) coef[k] = 16'(16'h0080 * (k + 1));
    send(16'h0400, 0, '0, y);
    chk("impulse_0", y, 16'h0080);
    for (int j = 1; j < NT; j++) begin
      send(16'h0000, 0, '0, y);
      chk("impulse_k", y, 16'(16'h0080 * (j + 1)));
    end
    send(16'h0000, 0, '0, y);
    chk("impulse_tail", y, 16'h0000);
  endtask

  initial begin
    logic [W-1:0] y;
    logic [W-1:0] v;
    int           de;
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    for (int k = 0; k < NT; k++) begin
      coef[k] = '0;
      mx[k]   = '0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    run_impulse();

    do_reset();
    for (int k = 0; k < NT; k++) coef[k] = 16'h0400;
    for (int j = 0; j < 10; j++) begin
      send(16'h0400, 0, '0, y);
      chk("dc_step", y, (j < NT) ? 16'(16'h0400 * (j + 1)) : 16'h2000);
    end

    do_reset();
    for (int j = 0; j < 4; j++) begin
      send(16'h7000, 0, '0, y);
      chk("pos_sat", y, (j == 0) ? 16'h7000 : 16'h7FFF);
    end

    do_reset();
    for (int j = 0; j < 4; j++) begin
      send(16'h8000, 0, '0, y);
      chk("neg_sat", y, 16'h8000);
    end

    do_reset();
    for (int k = 0; k < NT; k++) coef[k] = 16'(16'h0080 * (k + 1));
    send(16'h0400, 3, 16'h0200, y);
    chk("drop_first", y, 16'h0080);
    for (int j = 1; j < NT; j++) begin
      send(16'h0000, 0, '0, y);
      chk("drop_shift_once", y, 16'(16'h0080 * (j + 1)));
    end
    send(16'h0000, 9, 16'h7777, y);
    chk("drop_in_done", y, 16'h0000);

    // Reset lands while idx == 4; no result may escape for that sample.
    @(negedge clk);
    bus.sample_in    = 16'h1234;
    bus.sample_valid = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.sample_valid = 1'b0;
    end
    chk("mid_coef_addr", bus.coef_addr, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_y_out", bus.y_out, 0);
    chk("mid_rst_y_valid", bus.y_valid, 0);
    chk("mid_rst_coef_addr", bus.coef_addr, 0);
    chk("mid_rst_mult_a", bus.mult_a, 0);
    chk("mid_rst_mult_b", bus.mult_b, 0);
    for (int k = 0; k < NT; k++) mx[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk("no_partial_valid", bus.y_valid, 0);
    end
    run_impulse();

    do_reset();
    for (int k = 0; k < NT; k++) coef[k] = 16'($urandom);
    for (int j = 0; j < 24; j++) begin
      v  = 16'($signed(16'($urandom)) >>> $urandom_range(0, 6));
      de = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      send(v, de, 16'($urandom), y);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
